// File: rtl/snake_board.sv
// Bit-per-cell 32x16 snake playfield: registered VGA read port plus a game command port.
// Optional macro SNAKE_BOARD_COLLIDE_EN enables prior-occupancy reporting on rsp_hit.
`timescale 1ns/1ps

module snake_board #(
  parameter int COLS = 32,
  parameter int ROWS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] board_x,
  input  logic [4:0] board_y,
  output logic       board_out,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_x,
  input  logic [4:0] cmd_y,
  output logic       rsp_valid,
  output logic       rsp_hit
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [5:0]    COL_LIM  = 6'(COLS);
  localparam logic [4:0]    ROW_LIM  = 5'(ROWS);
  localparam logic [YW-1:0] LAST_ROW = YW'(ROWS - 1);

  typedef enum logic [1:0] {
    OP_QUERY     = 2'b00,
    OP_SET       = 2'b01,
    OP_CLEAR     = 2'b10,
    OP_CLEAR_ALL = 2'b11
  } op_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t                     state;
  logic [YW-1:0]              cnt;
  logic [ROWS-1:0][COLS-1:0]  cells;

  op_t           op;
  logic          rd_on;
  logic          cmd_on;
  logic [XW-1:0] rd_col;
  logic [YW-1:0] rd_row;
  logic [XW-1:0] cmd_col;
  logic [YW-1:0] cmd_row;

  assign op      = op_t'(cmd_op);
  assign rd_on   = (board_x < COL_LIM) && (board_y < ROW_LIM);
  assign cmd_on  = (cmd_x < COL_LIM) && (cmd_y < ROW_LIM);
  assign rd_col  = board_x[XW-1:0];
  assign rd_row  = board_y[YW-1:0];
  assign cmd_col = cmd_x[XW-1:0];
  assign cmd_row = cmd_y[YW-1:0];

  // Reads sample the array before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_out <= 1'b0;
    end else begin
      board_out <= rd_on ? cells[rd_row][rd_col] : 1'b0;
    end
  end

`ifdef SNAKE_BOARD_COLLIDE_EN
  logic hit_q;
  assign rsp_hit = hit_q;
`else
  assign rsp_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      cnt       <= '0;
      cells     <= '0;
`ifdef SNAKE_BOARD_COLLIDE_EN
      hit_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (op == OP_CLEAR_ALL) begin
              state     <= SWEEP;
              cmd_ready <= 1'b0;
              cnt       <= '0;
            end else begin
              rsp_valid <= 1'b1;
`ifdef SNAKE_BOARD_COLLIDE_EN
              // Off-board targets count as a wall hit.
              hit_q <= cmd_on ? cells[cmd_row][cmd_col] : 1'b1;
`endif
              if (cmd_on && op == OP_SET) begin
                cells[cmd_row][cmd_col] <= 1'b1;
              end else if (cmd_on && op == OP_CLEAR) begin
                cells[cmd_row][cmd_col] <= 1'b0;
              end
            end
          end
        end
        SWEEP: begin
          cells[cnt] <= '0;
          if (cnt == LAST_ROW) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            cnt       <= '0;
`ifdef SNAKE_BOARD_COLLIDE_EN
            hit_q     <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_board.sv
// Directed self-checking bench for snake_board: reset, commands, off-board, sweep, read/write race.
`timescale 1ns/1ps

module tb_snake_board;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] board_x;
  logic [4:0] board_y;
  logic       board_out;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_x;
  logic [4:0] cmd_y;
  logic       rsp_valid;
  logic       rsp_hit;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0][31:0] model;

`ifdef SNAKE_BOARD_COLLIDE_EN
  localparam bit COLLIDE = 1'b1;
`else
  localparam bit COLLIDE = 1'b0;
`endif

  snake_board #(.COLS(32), .ROWS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .board_x(board_x), .board_y(board_y), .board_out(board_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit)
  );

  always #5 clk = ~clk;

  function automatic logic hit_exp(input logic v);
    return COLLIDE ? v : 1'b0;
  endfunction

  // Presents one command for one accepting edge; returns at the negedge after it.
  task automatic issue(input logic [1:0] op, input logic [5:0] x, input logic [4:0] y);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (board_out !== 1'b0) begin n_err++; $display("FAIL reset_board_out: got %b expected 0", board_out); end
    rst_n = 1'b1;
    for (int i = 0; i <= 512; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (board_out !== model[(i-1)/32][(i-1)%32]) begin
          n_err++; $display("FAIL reset_scan (%0d,%0d): got %b expected %b", (i-1)%32, (i-1)/32, board_out, model[(i-1)/32][(i-1)%32]);
        end
      end
      if (i < 512) begin board_x = 6'(i % 32); board_y = 5'(i / 32); end
    end
  endtask

  task automatic test_set_query;
    issue(2'b01, 6'd5, 5'd3);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL set_rsp_valid: got %b expected 1", rsp_valid); end
    n_cmp++; if (rsp_hit !== hit_exp(1'b0)) begin n_err++; $display("FAIL set_first_hit: got %b expected %b", rsp_hit, hit_exp(1'b0)); end
    board_x = 6'd5; board_y = 5'd3;
    model[3][5] = 1'b1;
    @(negedge clk);
    n_cmp++; if (board_out !== 1'b1) begin n_err++; $display("FAIL set_visible: got %b expected 1", board_out); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL set_rsp_one_cycle: got %b expected 0", rsp_valid); end
    issue(2'b00, 6'd5, 5'd3);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL query_rsp_valid: got %b expected 1", rsp_valid); end
    n_cmp++; if (rsp_hit !== hit_exp(1'b1)) begin n_err++; $display("FAIL query_hit: got %b expected %b", rsp_hit, hit_exp(1'b1)); end
    issue(2'b01, 6'd5, 5'd3);
    n_cmp++; if (rsp_hit !== hit_exp(1'b1)) begin n_err++; $display("FAIL set_again_hit: got %b expected %b", rsp_hit, hit_exp(1'b1)); end
  endtask

  task automatic test_off_board;
    issue(2'b01, 6'd40, 5'd3);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL off_x_rsp_valid: got %b expected 1", rsp_valid); end
    n_cmp++; if (rsp_hit !== hit_exp(1'b1)) begin n_err++; $display("FAIL off_x_hit: got %b expected %b", rsp_hit, hit_exp(1'b1)); end
    issue(2'b01, 6'd2, 5'd20);
    n_cmp++; if (rsp_hit !== hit_exp(1'b1)) begin n_err++; $display("FAIL off_y_hit: got %b expected %b", rsp_hit, hit_exp(1'b1)); end
    issue(2'b00, 6'd63, 5'd31);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL off_query_rsp_valid: got %b expected 1", rsp_valid); end
    n_cmp++; if (rsp_hit !== hit_exp(1'b1)) begin n_err++; $display("FAIL off_query_hit: got %b expected %b", rsp_hit, hit_exp(1'b1)); end
    // (37,3) and (5,19) alias (5,3) if the range check is missing.
    board_x = 6'd37; board_y = 5'd3;
    @(negedge clk);
    board_x = 6'd5; board_y = 5'd19;
    n_cmp++; if (board_out !== 1'b0) begin n_err++; $display("FAIL off_read_x: got %b expected 0", board_out); end
    @(negedge clk);
    n_cmp++; if (board_out !== 1'b0) begin n_err++; $display("FAIL off_read_y: got %b expected 0", board_out); end
    for (int i = 0; i <= 512; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (board_out !== model[(i-1)/32][(i-1)%32]) begin
          n_err++; $display("FAIL off_scan (%0d,%0d): got %b expected %b", (i-1)%32, (i-1)/32, board_out, model[(i-1)/32][(i-1)%32]);
        end
      end
      if (i < 512) begin board_x = 6'(i % 32); board_y = 5'(i / 32); end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_x = 6'd1; cmd_y = 5'd1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_hit !== hit_exp(1'b0)) begin n_err++; $display("FAIL b2b_set: got v=%b h=%b expected v=1 h=%b", rsp_valid, rsp_hit, hit_exp(1'b0)); end
    cmd_op = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_hit !== hit_exp(1'b1)) begin n_err++; $display("FAIL b2b_query: got v=%b h=%b expected v=1 h=%b", rsp_valid, rsp_hit, hit_exp(1'b1)); end
    cmd_op = 2'b10;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_hit !== hit_exp(1'b1)) begin n_err++; $display("FAIL b2b_clear: got v=%b h=%b expected v=1 h=%b", rsp_valid, rsp_hit, hit_exp(1'b1)); end
    cmd_op = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_hit !== hit_exp(1'b0)) begin n_err++; $display("FAIL b2b_query_after_clear: got v=%b h=%b expected v=1 h=%b", rsp_valid, rsp_hit, hit_exp(1'b0)); end
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_same_edge;
    @(negedge clk);
    board_x = 6'd9; board_y = 5'd9;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_x = 6'd9; cmd_y = 5'd9;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++; if (board_out !== 1'b0) begin n_err++; $display("FAIL same_edge_old: got %b expected 0", board_out); end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL same_edge_rsp: got %b expected 1", rsp_valid); end
    model[9][9] = 1'b1;
    @(negedge clk);
    n_cmp++; if (board_out !== 1'b1) begin n_err++; $display("FAIL same_edge_new: got %b expected 1", board_out); end
  endtask

  task automatic test_clear_all;
    int lows;
    int pulses;
    lows = 0; pulses = 0;
    issue(2'b01, 6'd0, 5'd0);
    issue(2'b01, 6'd31, 5'd15);
    issue(2'b01, 6'd7, 5'd8);
    model[0][0] = 1'b1; model[15][31] = 1'b1; model[8][7] = 1'b1;
    @(negedge clk);
    board_x = 6'd31; board_y = 5'd15;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_x = 6'd0; cmd_y = 5'd0;
    // j counts edges after the accepting edge N; sampled at the following negedge.
    for (int j = 0; j <= 17; j++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (cmd_ready === 1'b0) lows++;
      if (rsp_valid === 1'b1) begin
        pulses++;
        n_cmp++; if (j != 16 || rsp_hit !== 1'b0) begin n_err++; $display("FAIL sweep_rsp_at: got edge N+%0d hit=%b expected edge N+16 hit=0", j, rsp_hit); end
      end
      if (j <= 16) begin
        n_cmp++; if (board_out !== 1'b1) begin n_err++; $display("FAIL sweep_read_31_15 N+%0d: got %b expected 1", j, board_out); end
      end else begin
        n_cmp++; if (board_out !== 1'b0) begin n_err++; $display("FAIL sweep_read_after: got %b expected 0", board_out); end
      end
    end
    n_cmp++; if (lows != 16) begin n_err++; $display("FAIL sweep_ready_low_cycles: got %0d expected 16", lows); end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL sweep_rsp_pulses: got %0d expected 1", pulses); end
    model = '0;
    for (int i = 0; i <= 512; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (board_out !== model[(i-1)/32][(i-1)%32]) begin
          n_err++; $display("FAIL sweep_scan (%0d,%0d): got %b expected %b", (i-1)%32, (i-1)/32, board_out, model[(i-1)/32][(i-1)%32]);
        end
      end
      if (i < 512) begin board_x = 6'(i % 32); board_y = 5'(i / 32); end
    end
  endtask

  task automatic test_reset_mid_sweep;
    int pulses;
    pulses = 0;
    issue(2'b01, 6'd4, 5'd4);
    issue(2'b01, 6'd20, 5'd12);
    issue(2'b11, 6'd0, 5'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midreset_rsp_valid: got %b expected 0", rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL midreset_spurious_rsp: got %0d expected 0", pulses); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midreset_idle_ready: got %b expected 1", cmd_ready); end
    for (int i = 0; i <= 512; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (board_out !== 1'b0) begin
          n_err++; $display("FAIL midreset_scan (%0d,%0d): got %b expected 0", (i-1)%32, (i-1)/32, board_out);
        end
      end
      if (i < 512) begin board_x = 6'(i % 32); board_y = 5'(i / 32); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    board_x = '0; board_y = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
    model = '0;
    test_reset;
    test_set_query;
    test_off_board;
    test_back_to_back;
    test_same_edge;
    test_clear_all;
    test_reset_mid_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
